// File: rtl/scan_chain_ctrl.sv
// Sequencer for a mux-flop configuration chain: serial shift with readback, parallel capture and
// synchronous clear. Define SCAN_PARITY_EN to build even parity over the read-back word.
module scan_chain_ctrl #(
    parameter int unsigned CHAIN_LEN = 32,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned DIV       = 0
) (
    input  logic                 CK,
    input  logic                 CDN,
    input  logic                 start,
    input  logic [1:0]           cmd,
    input  logic [CHAIN_LEN-1:0] wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 sd,
    output logic                 sp,
    output logic                 sr,
    output logic                 sdo,
    input  logic                 sdi,
    output logic [CHAIN_LEN-1:0] rdata,
    output logic                 rpar
);

    typedef enum logic [2:0] {StIdle, StShift, StCapture, StClear, StDone} state_e;

    localparam logic [1:0] CmdShift   = 2'b00;
    localparam logic [1:0] CmdCapture = 2'b01;
    localparam logic [1:0] CmdClear   = 2'b10;
    localparam logic [1:0] CmdRsvd    = 2'b11;

    state_e               state_q;
    logic [1:0]           cmd_q;
    logic [CHAIN_LEN-1:0] shreg_q;
    logic [CHAIN_LEN-1:0] rdata_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [3:0]           divcnt_q;
    logic                 busy_q, done_q, err_q, sd_q, sp_q, sr_q, sdo_q;

    logic                 chain_shift;
    logic                 step;
    logic [CHAIN_LEN-1:0] shreg_in;

    // The chain moves on the edge that ends a cycle with sp/sd visible, so sdi is taken then.
    assign chain_shift = sp_q & sd_q;
    assign step        = (divcnt_q == 4'(DIV));
    assign shreg_in    = {sdi, shreg_q[CHAIN_LEN-1:1]};

    always_ff @(posedge CK or negedge CDN) begin
        if (!CDN) begin
            state_q  <= StIdle;
            cmd_q    <= CmdShift;
            shreg_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            divcnt_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            sd_q     <= 1'b0;
            sp_q     <= 1'b0;
            sr_q     <= 1'b0;
            sdo_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            sp_q   <= 1'b0;
            sr_q   <= 1'b0;
            if (chain_shift) begin
                shreg_q <= shreg_in;
            end
            unique case (state_q)
                StIdle: begin
                    sd_q <= 1'b0;
                    if (start) begin
                        cmd_q  <= cmd;
                        busy_q <= 1'b1;
                        unique case (cmd)
                            CmdShift: begin
                                shreg_q  <= wdata;
                                cnt_q    <= '0;
                                divcnt_q <= '0;
                                state_q  <= StShift;
                            end
                            CmdCapture: state_q <= StCapture;
                            CmdClear:   state_q <= StClear;
                            CmdRsvd:    state_q <= StDone;
                        endcase
                    end
                end
                StShift: begin
                    sd_q <= 1'b1;
                    if (step) begin
                        sp_q     <= 1'b1;
                        // With DIV = 0 the previous bit leaves shreg on this same edge.
                        sdo_q    <= chain_shift ? shreg_q[1] : shreg_q[0];
                        divcnt_q <= '0;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                            state_q <= StDone;
                        end
                    end else begin
                        divcnt_q <= divcnt_q + 4'd1;
                    end
                end
                StCapture: begin
                    sd_q    <= 1'b0;
                    sp_q    <= 1'b1;
                    state_q <= StDone;
                end
                StClear: begin
                    sr_q    <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    sd_q    <= 1'b0;
                    done_q  <= 1'b1;
                    err_q   <= (cmd_q == CmdRsvd);
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                    if (chain_shift) begin
                        rdata_q <= shreg_in;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef SCAN_PARITY_EN
    logic rpar_q;

    always_ff @(posedge CK or negedge CDN) begin
        if (!CDN) begin
            rpar_q <= 1'b0;
        end else if (state_q == StDone && chain_shift) begin
            rpar_q <= ^shreg_in;
        end
    end

    assign rpar = rpar_q;
`else
    assign rpar = 1'b0;
`endif

    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign sd    = sd_q;
    assign sp    = sp_q;
    assign sr    = sr_q;
    assign sdo   = sdo_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: two instances (DIV = 0 and DIV = 2) each driving a behavioural
// mux-flop chain; results are checked against expectations derived from the command rules.
module tb_scan_chain_ctrl;

    localparam int unsigned N = 8;

    logic CK = 1'b0;
    logic CDN;
    always #5 CK = ~CK;

    logic [1:0]   start, busy, done, err, sd, sp, sr, sdo, sdi, rpar, pl_en;
    logic [1:0]   cmd     [2];
    logic [N-1:0] wdata   [2];
    logic [N-1:0] rdata   [2];
    logic [N-1:0] d0      [2];
    logic [N-1:0] chain   [2];
    logic [N-1:0] pl_val  [2];
    logic [N-1:0] last_rd [2];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 2; g++) begin : g_u
        scan_chain_ctrl #(
            .CHAIN_LEN(N),
            .CNT_W    (4),
            .DIV      ((g == 0) ? 0 : 2)
        ) dut (
            .CK   (CK),
            .CDN  (CDN),
            .start(start[g]),
            .cmd  (cmd[g]),
            .wdata(wdata[g]),
            .busy (busy[g]),
            .done (done[g]),
            .err  (err[g]),
            .sd   (sd[g]),
            .sp   (sp[g]),
            .sr   (sr[g]),
            .sdo  (sdo[g]),
            .sdi  (sdi[g]),
            .rdata(rdata[g]),
            .rpar (rpar[g])
        );
    end

    // Chain of mux flops: SR clears, SP enables, SD picks serial (enters at MSB) or parallel D0.
    assign sdi = {chain[1][0], chain[0][0]};
    always @(posedge CK) begin
        for (int i = 0; i < 2; i++) begin
            if (pl_en[i])   chain[i] <= pl_val[i];
            else if (sr[i]) chain[i] <= '0;
            else if (sp[i]) chain[i] <= sd[i] ? {sdo[i], chain[i][N-1:1]} : d0[i];
        end
    end

    task automatic cyc();
        @(posedge CK);
        #1;
    endtask

    task automatic preload(input int u, input logic [N-1:0] v);
        pl_val[u] = v;
        pl_en[u]  = 1'b1;
        cyc();
        pl_en[u]  = 1'b0;
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            total++;
            if ({busy[u], done[u], err[u], sd[u], sp[u], sr[u], sdo[u], rpar[u]} !== 8'h00) begin
                bad++;
                $display("FAIL reset_ctl u%0d: got %b want 00000000", u,
                         {busy[u], done[u], err[u], sd[u], sp[u], sr[u], sdo[u], rpar[u]});
            end
            total++;
            if (rdata[u] !== '0) begin
                bad++;
                $display("FAIL reset_rdata u%0d: got %h want 00", u, rdata[u]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int k = 0, nsp = 0, nd = 0;
        preload(0, N'($urandom));
        wdata[0] = N'($urandom);
        cmd[0]   = 2'b00;
        start[0] = 1'b1;
        while (nsp < 3 && k < 40) begin
            cyc();
            k++;
            start[0] = 1'b0;
            if (sp[0]) nsp++;
        end
        total++;
        if (nsp != 3) begin
            bad++;
            $display("FAIL reset_mid_reach: got %0d steps want 3", nsp);
        end
        CDN = 1'b0;
        #1;
        total++;
        if ({busy[0], sd[0], sp[0], sr[0], done[0]} !== 5'b0) begin
            bad++;
            $display("FAIL reset_mid_ctl: got %b want 00000", {busy[0], sd[0], sp[0], sr[0], done[0]});
        end
        cyc();
        cyc();
        CDN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (done[0] || busy[0]) nd++;
        end
        total++;
        if (nd != 0) begin
            bad++;
            $display("FAIL reset_mid_done: got %0d active cycles want 0", nd);
        end
        total++;
        if (rdata[0] !== '0) begin
            bad++;
            $display("FAIL reset_mid_rdata: got %h want 00", rdata[0]);
        end
        last_rd[0] = '0;
        last_rd[1] = '0;
    endtask

    task automatic run_shift(input int u, input logic [N-1:0] pre, input logic [N-1:0] w,
                             input int poke_k, input string tag);
        int k = 0, nsp = 0, last = -1, ctl_bad = 0, div, lat;
        logic exp_par;
        div = (u == 0) ? 0 : 2;
        lat = 1 + int'(N) * (div + 1) + 1;
        preload(u, pre);
        wdata[u] = w;
        cmd[u]   = 2'b00;
        start[u] = 1'b1;
        do begin
            cyc();
            k++;
            if (k == 1) start[u] = 1'b0;
            if (poke_k > 0 && k == poke_k) begin
                start[u] = 1'b1;
                cmd[u]   = 2'b10;
            end
            if (poke_k > 0 && k == poke_k + 1) start[u] = 1'b0;
            if (sp[u]) begin
                if (!sd[u]) ctl_bad++;
                if (last >= 0 && k - last != div + 1) ctl_bad++;
                last = k;
                nsp++;
            end
            if (nsp > 0 && nsp < int'(N) && !sd[u]) ctl_bad++;
            if (sr[u]) ctl_bad++;
            if (!done[u] && !busy[u]) ctl_bad++;
        end while (!done[u] && k < 400);
        start[u] = 1'b0;
`ifdef SCAN_PARITY_EN
        exp_par = ^pre;
`else
        exp_par = 1'b0;
`endif
        total++;
        if (done[u] !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout: got no done want done", tag);
        end
        total++;
        if (k != lat) begin
            bad++;
            $display("FAIL %s_latency: got %0d want %0d", tag, k, lat);
        end
        total++;
        if (nsp != int'(N)) begin
            bad++;
            $display("FAIL %s_sp_count: got %0d want %0d", tag, nsp, N);
        end
        total++;
        if (ctl_bad != 0) begin
            bad++;
            $display("FAIL %s_controls: got %0d violations want 0", tag, ctl_bad);
        end
        total++;
        if (chain[u] !== w) begin
            bad++;
            $display("FAIL %s_chain: got %h want %h", tag, chain[u], w);
        end
        total++;
        if (rdata[u] !== pre) begin
            bad++;
            $display("FAIL %s_rdata: got %h want %h", tag, rdata[u], pre);
        end
        total++;
        if (rpar[u] !== exp_par) begin
            bad++;
            $display("FAIL %s_rpar: got %b want %b", tag, rpar[u], exp_par);
        end
        total++;
        if (busy[u] !== 1'b0 || err[u] !== 1'b0) begin
            bad++;
            $display("FAIL %s_done_flags: got busy=%b err=%b want 0 0", tag, busy[u], err[u]);
        end
        last_rd[u] = pre;
    endtask

    task automatic test_ignore_start();
        int act = 0;
        logic [N-1:0] w;
        w = N'($urandom);
        run_shift(1, N'($urandom), w, 5, "ignore");
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (busy[1] || done[1] || sr[1] || sp[1]) act++;
        end
        total++;
        if (act != 0 || chain[1] !== w) begin
            bad++;
            $display("FAIL ignore_queued: got %0d active cycles chain %h want 0 and %h", act,
                     chain[1], w);
        end
    endtask

    task automatic test_capture(input int u);
        int k = 0, ncap = 0, nother = 0;
        d0[u] = (u == 0) ? 8'h5A : N'($urandom);
        preload(u, N'($urandom));
        cmd[u]   = 2'b01;
        start[u] = 1'b1;
        do begin
            cyc();
            k++;
            start[u] = 1'b0;
            if (sp[u] && !sd[u]) ncap++;
            if (sr[u] || (sp[u] && sd[u])) nother++;
        end while (!done[u] && k < 20);
        total++;
        if (done[u] !== 1'b1 || ncap != 1 || nother != 0) begin
            bad++;
            $display("FAIL capture_ctl u%0d: got done=%b cap=%0d other=%0d want 1 1 0", u,
                     done[u], ncap, nother);
        end
        total++;
        if (chain[u] !== d0[u]) begin
            bad++;
            $display("FAIL capture_chain u%0d: got %h want %h", u, chain[u], d0[u]);
        end
        total++;
        if (rdata[u] !== last_rd[u]) begin
            bad++;
            $display("FAIL capture_rdata u%0d: got %h want %h", u, rdata[u], last_rd[u]);
        end
    endtask

    task automatic test_clear(input int u);
        int k = 0, nclr = 0, nsp = 0;
        preload(u, N'($urandom) | 8'h01);
        cmd[u]   = 2'b10;
        start[u] = 1'b1;
        do begin
            cyc();
            k++;
            start[u] = 1'b0;
            if (sr[u]) nclr++;
            if (sp[u]) nsp++;
        end while (!done[u] && k < 20);
        total++;
        if (done[u] !== 1'b1 || nclr != 1 || nsp != 0 || err[u] !== 1'b0) begin
            bad++;
            $display("FAIL clear_ctl u%0d: got done=%b sr=%0d sp=%0d err=%b want 1 1 0 0", u,
                     done[u], nclr, nsp, err[u]);
        end
        total++;
        if (chain[u] !== '0 || rdata[u] !== last_rd[u]) begin
            bad++;
            $display("FAIL clear_data u%0d: got chain=%h rdata=%h want 00 %h", u, chain[u],
                     rdata[u], last_rd[u]);
        end
    endtask

    task automatic test_error(input int u);
        int k = 0, nsp = 0;
        logic [N-1:0] pre;
        pre = N'($urandom);
        preload(u, pre);
        cmd[u]   = 2'b11;
        start[u] = 1'b1;
        do begin
            cyc();
            k++;
            start[u] = 1'b0;
            if (sp[u] || sr[u]) nsp++;
        end while (!done[u] && k < 20);
        total++;
        if (k != 2 || err[u] !== 1'b1 || done[u] !== 1'b1) begin
            bad++;
            $display("FAIL error_pulse u%0d: got k=%0d done=%b err=%b want 2 1 1", u, k,
                     done[u], err[u]);
        end
        total++;
        if (nsp != 0 || chain[u] !== pre || rdata[u] !== last_rd[u]) begin
            bad++;
            $display("FAIL error_side u%0d: got ctl=%0d chain=%h rdata=%h want 0 %h %h", u,
                     nsp, chain[u], rdata[u], pre, last_rd[u]);
        end
        cyc();
        total++;
        if (err[0] !== 1'b0 || done[0] !== 1'b0) begin
            bad++;
            $display("FAIL error_width u%0d: got done=%b err=%b want 0 0", u, done[0], err[0]);
        end
    endtask

    task automatic test_back_to_back();
        int ndone = 0, extra = 0;
        run_shift(0, N'($urandom), N'($urandom), 0, "b2b_shift");
        cmd[0]   = 2'b11;
        start[0] = 1'b1;
        cyc();
        start[0] = 1'b0;
        cyc();
        total++;
        if (done[0] !== 1'b1 || err[0] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept: got done=%b err=%b want 1 1", done[0], err[0]);
        end
        cyc();
        start[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (done[0]) ndone++;
        end
        start[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (done[0] || busy[0]) extra++;
        end
        total++;
        if (ndone != 5 || extra != 0) begin
            bad++;
            $display("FAIL b2b_held: got %0d dones %0d extra want 5 0", ndone, extra);
        end
    endtask

    initial begin
        start = '0;
        pl_en = '0;
        for (int i = 0; i < 2; i++) begin
            cmd[i]     = 2'b00;
            wdata[i]   = '0;
            d0[i]      = '0;
            pl_val[i]  = '0;
            last_rd[i] = '0;
        end
        CDN = 1'b1;
        #2 CDN = 1'b0;
        #20;
        test_reset();
        @(negedge CK);
        CDN = 1'b1;
        cyc();
        test_reset_mid();
        run_shift(0, 8'hA5, 8'h3C, 0, "shift_div0");
        run_shift(1, 8'hA5, 8'h3C, 0, "shift_div2");
        for (int i = 0; i < 4; i++) begin
            run_shift(i % 2, N'($urandom), N'($urandom), 0, "shift_rand");
        end
        test_ignore_start();
        test_capture(0);
        test_capture(1);
        test_clear(0);
        test_clear(1);
        test_error(0);
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Sequencer for a serial configuration chain built from mux-input, clock-enabled flops (D0 parallel / D1 serial, SD select, SP enable, SR sync clear).
- Accepts one command at a time and drives the chain's shared SD/SP/SR controls and serial head input.
- Shifts a new word in while reading the old word back, and also supports parallel capture and synchronous clear.
- Sits between the configuration register interface and the chain of mux flops.

Parameters:
CHAIN_LEN, 32, number of flops in the chain (2..256)
CNT_W, 8, width of the shift counter; must satisfy 2**CNT_W >= CHAIN_LEN
DIV, 0, shift-rate divider; one shift step every DIV+1 CK cycles (0..15)

Ports:
CK  input  1  clock; all state updates on the rising edge
CDN  input  1  asynchronous active-low reset
start  input  1  command strobe; sampled only in IDLE
cmd  input  2  00 = shift, 01 = capture, 10 = clear, 11 = reserved
wdata  input  CHAIN_LEN  word to shift in; bit 0 leaves first
busy  output  1  high from the cycle after an accepted start until DONE exits
done  output  1  one-cycle pulse on command completion
err  output  1  one-cycle pulse with done when cmd = 11
sd  output  1  chain mux select; 1 = serial path (D1), 0 = parallel path (D0)
sp  output  1  chain clock enable
sr  output  1  chain synchronous clear
sdo  output  1  serial data into chain head
sdi  input  1  serial data from chain tail
rdata  output  CHAIN_LEN  old chain contents captured by the last shift command
rpar  output  1  even parity of rdata (see Optional Feature)

Behaviour:
- Reset (CDN = 0, asynchronous): state = IDLE.
- Outputs at reset: busy = 0, done = 0, err = 0, sd = 0, sp = 0, sr = 0, sdo = 0.
- Registers at reset: rdata = 0, rpar = 0, shreg = 0, cnt = 0, divcnt = 0.
- All outputs are registered.
- States: IDLE, SHIFT, CAPTURE, CLEAR, DONE.
- IDLE:
  - On start = 1, latch cmd.
  - cmd = 00: shreg <= wdata, cnt <= 0, divcnt <= 0, go to SHIFT.
  - cmd = 01: go to CAPTURE.
  - cmd = 10: go to CLEAR.
  - cmd = 11: go to DONE with err set.
  - start is ignored in every other state; no queueing.
- SHIFT:
  - sd = 1 throughout.
  - sp = 1 only on step cycles, i.e. when divcnt == DIV; otherwise divcnt increments.
  - On a step cycle:
    - sdo = shreg[0].
    - shreg <= {sdi, shreg[CHAIN_LEN-1:1]}.
    - divcnt <= 0.
    - cnt increments.
  - sdo is presented in the same cycle that sp is high, so the chain samples it on that edge.
  - After step CHAIN_LEN (cnt == CHAIN_LEN-1 on the step cycle), go to DONE.
  - rdata <= shreg with the final sdi inserted, so rdata[0] = old chain bit 0 (head) … rdata[CHAIN_LEN-1] = old tail bit.
  - Latency: accepted start to done = 1 + CHAIN_LEN*(DIV+1) + 1 cycles.
- CAPTURE: sd = 0, sp = 1 for exactly one cycle (chain loads D0), then DONE. rdata is unchanged.
- CLEAR: sr = 1, sp = 0 for exactly one cycle, then DONE. rdata is unchanged.
- DONE:
  - done = 1 (and err = 1 if cmd = 11) for one cycle.
  - sp = sd = sr = 0.
  - Return to IDLE; busy drops in the same cycle done is high.
  - A new start is accepted on the first IDLE cycle.
- sp, sr and the sd = 0 capture are never asserted outside their state; sd and sp never glitch between steps.
- Reset mid-command: immediate return to IDLE with all control outputs low. The chain is left partially shifted; no done is issued. rdata keeps its reset value of 0.
- start held high continuously: one command per IDLE visit.

Optional Feature:
- SCAN_PARITY_EN defined: rpar <= ^(final rdata value), registered in the same cycle rdata updates (end of SHIFT). CAPTURE, CLEAR and error commands leave rpar unchanged.
- SCAN_PARITY_EN not defined: rpar is tied to 0 and no parity logic is built. The port is present in both builds.

Test Plan:
- Reset with CHAIN_LEN = 8, DIV = 0 -> all outputs 0; assert CDN mid-SHIFT at step 3 -> sd = sp = 0 next cycle, no done pulse.
- Shift with chain model preloaded 8'hA5, wdata = 8'h3C -> exactly 8 sp pulses; chain = 8'h3C; rdata = 8'hA5; done on cycle 10 after start; rpar = 0 with SCAN_PARITY_EN.
- Same shift with DIV = 2 -> sp high one cycle in three; done 26 cycles after start.
- cmd = 01 with chain D0 = 8'h5A -> a single cycle with sd = 0, sp = 1; chain = 8'h5A; rdata unchanged.
- cmd = 10 -> a single cycle with sr = 1, sp = 0; chain = 0; done asserted.
- cmd = 11 -> done and err pulse together 2 cycles after start; a start pulsed during SHIFT is ignored; back-to-back start is accepted on the first IDLE cycle.
